decoder_pipe: RTL and testbench
===============================

Name: decoder_pipe

Overview:
- Parametrised, pipelined binary-to-one-hot/thermometer decoder; the registered, flow-controlled successor to the fixed-width combinational decoder.
- Splits the index into high and low fields, predecodes each in stage 1, and combines them in stage 2.
- Valid/ready on both sides; full throughput of one decode per cycle.
- Flags indices outside the implemented output width.

Parameters:
IN_WIDTH, 8, index width in bits
OUT_WIDTH, 2**IN_WIDTH, output vector width; legal range 2 .. 2**IN_WIDTH
LO_BITS, IN_WIDTH/2, width of the low predecode field; legal range 1 .. IN_WIDTH-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream has an index
in_ready  output  1  block accepts an index this cycle
in_bits  input  IN_WIDTH  index to decode
in_mode  input  1  0 = one-hot, 1 = thermometer
out_valid  output  1  out_bits/out_err are valid
out_ready  input  1  downstream accepts this cycle
out_bits  output  OUT_WIDTH  decoded vector
out_err  output  1  index >= OUT_WIDTH

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: clears s1_valid, s2_valid, out_valid, out_bits and out_err to 0. in_ready reads 1 out of reset. Reset mid-operation discards in-flight entries; no partial output is produced.
- Transfer rule: a transfer occurs when valid and ready are both 1 on a rising edge.
- Stage 1: captures on an input transfer.
  - hi_oh = one-hot of in_bits[IN_WIDTH-1:LO_BITS].
  - hi_gt = bit j set iff j < high field.
  - lo_oh = one-hot of the low field.
  - lo_th = bits 0..low field set.
  - Also captures mode and err = (in_bits >= OUT_WIDTH).
- Stage 2: registers out_bits.
  - One-hot: bit i = hi_oh[i>>LO_BITS] & lo_oh[i & mask].
  - Thermometer: bit i = hi_gt[i>>LO_BITS] | (hi_oh[i>>LO_BITS] & lo_th[i & mask]).
  - With err = 1, out_bits = 0 in both modes.
- Latency: exactly 2 cycles from input transfer to out_valid, with no backpressure.
- Flow control:
  - s2 advances when !s2_valid or out_ready.
  - s1 advances when !s1_valid or s2 advances.
  - in_ready = s1 advance condition (combinational from out_ready through two levels; no combinational path from in_valid to in_ready).
- Stall: out_bits and out_err hold stable while out_valid=1 and out_ready=0.
- Full/empty: the pipeline holds up to 2 entries. With both stages full and out_ready=0, in_ready=0.
- Simultaneous events: an input transfer and an output transfer in the same cycle with both stages full are legal; one entry leaves and one enters, with no bubble.
- Width rule: the index compare is done at IN_WIDTH+1 bits so that OUT_WIDTH = 2**IN_WIDTH never flags an error. Output bits at or above OUT_WIDTH are not generated.

Optional Feature:
- Macro: DECODER_PIPE_COUNT_EN.
- When defined:
  - Adds output ports xfer_count[31:0] and err_count[31:0].
  - xfer_count increments on each output transfer; err_count increments on each output transfer with out_err=1.
  - Both wrap from 0xFFFFFFFF to 0 and reset to 0.
- When undefined: the ports and counters are absent. Decode behaviour is identical either way.

Decomposition:
- Package decoder_pkg:
  - MODE_ONEHOT=1'b0, MODE_THERM=1'b1.
  - Function clog2 for parameter checks.
  - Counter width constant COUNT_W=32.
- Sub-module decoder_pipe_slice: a generic one-entry valid/ready register slice, parametrised on payload width.
  - Instantiated twice, for the stage-1 payload and the stage-2 payload.
- Predecode and combine logic stays in decoder_pipe.

Test Plan:
- Reset, then in_bits=0, mode 0, out_ready=1 -> out_valid rises 2 cycles later with out_bits=8'h...01 (bit 0 only), out_err=0.
- in_bits=5, mode 1 -> out_bits = 0x3F in the low bits, all higher bits 0. in_bits=255, mode 1 -> all 256 bits 1.
- OUT_WIDTH=200, in_bits=201 -> out_err=1, out_bits=0. in_bits=199, mode 0 -> bit 199 only, out_err=0.
- Stream indices 0..9 back-to-back with out_ready=1 -> 10 outputs on 10 consecutive cycles, in order. Then hold out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts and out_bits stays stable; release -> no loss, no duplication.
- Assert rst_n=0 asynchronously mid-stream with 2 entries in flight -> out_valid falls immediately, and after release the first output corresponds to the first post-reset input.
- With DECODER_PIPE_COUNT_EN: 10 transfers, 3 of them erroring -> xfer_count=10, err_count=3. Preload near 0xFFFFFFFF -> count wraps to 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the pipelined index decoder.
//   mode_e  : decode mode carried alongside each index (one-hot or thermometer)
//   COUNT_W : width of the optional transfer/error counters
//   clog2   : ceiling log2, used for elaboration-time parameter checks
package decoder_pkg;

  typedef enum logic {
    MODE_ONEHOT = 1'b0,
    MODE_THERM  = 1'b1
  } mode_e;

  localparam int COUNT_W = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_pipe_if.sv
// Bus bundle for decoder_pipe.
//   in_valid/in_ready/in_bits/in_mode      : index request channel
//   out_valid/out_ready/out_bits/out_err   : decoded result channel
// Handshake: on each channel a transfer happens on a rising clock edge where
// valid and ready are both 1. A source holds valid and its payload stable
// until the transfer; ready never depends combinationally on valid.
// Modports: slave = the decoder, master = the agent driving it.
interface decoder_pipe_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2**IN_WIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_bits;
  logic                 in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_bits;
  logic                 out_err;

  modport slave (
    input  in_valid, in_bits, in_mode, out_ready,
    output in_ready, out_valid, out_bits, out_err
  );

  modport master (
    output in_valid, in_bits, in_mode, out_ready,
    input  in_ready, out_valid, out_bits, out_err
  );
endinterface

// File: rtl/decoder_pipe_slice.sv
// One-entry valid/ready register slice with a W-bit payload.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data payload
// Accepts a new entry whenever it is empty or its entry leaves in the same
// cycle, so a chain of slices runs at one transfer per cycle.
module decoder_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/decoder_pipe.sv
// Two-stage pipelined binary -> one-hot / thermometer decoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decoder_pipe_if.slave (index in, decoded vector + err out)
//   xfer_count, err_count : present only with DECODER_PIPE_COUNT_EN defined;
//                           count output transfers and errored output transfers
// Stage 1 predecodes the high and low index fields; stage 2 combines them into
// OUT_WIDTH output bits. Indices >= OUT_WIDTH raise out_err with out_bits = 0.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2**IN_WIDTH,
  parameter int LO_BITS   = IN_WIDTH/2
) (
  input logic clk,
  input logic rst_n,
  decoder_pipe_if.slave bus
`ifdef DECODER_PIPE_COUNT_EN
  ,
  output logic [COUNT_W-1:0] xfer_count,
  output logic [COUNT_W-1:0] err_count
`endif
);
  localparam int HI_BITS = IN_WIDTH - LO_BITS;
  localparam int HI_N    = 2**HI_BITS;
  localparam int LO_N    = 2**LO_BITS;
  localparam int LO_MASK = LO_N - 1;
  // One extra bit so OUT_WIDTH = 2**IN_WIDTH is representable and never errors.
  localparam logic [IN_WIDTH:0] OUT_LIMIT = (IN_WIDTH+1)'(OUT_WIDTH);

  if (LO_BITS < 1 || LO_BITS > IN_WIDTH - 1) begin : g_bad_lo_bits
    $error("decoder_pipe: LO_BITS must be in 1 .. IN_WIDTH-1");
  end
  if (OUT_WIDTH < 2 || clog2(OUT_WIDTH) > IN_WIDTH) begin : g_bad_out_width
    $error("decoder_pipe: OUT_WIDTH must be in 2 .. 2**IN_WIDTH");
  end

  typedef struct packed {
    mode_e            mode;
    logic             err;
    logic [HI_N-1:0]  hi_oh;  // one-hot of the high field
    logic [HI_N-1:0]  hi_gt;  // bit j set when j < high field
    logic [LO_N-1:0]  lo_oh;  // one-hot of the low field
    logic [LO_N-1:0]  lo_th;  // bits 0..low field set
  } s1_t;

  typedef struct packed {
    logic                 err;
    logic [OUT_WIDTH-1:0] bits;
  } s2_t;

  s1_t pre, s1;
  s2_t comb, s2;
  logic s1_valid, s2_ready;

  logic [HI_BITS-1:0] hi_field;
  logic [LO_BITS-1:0] lo_field;
  assign hi_field = bus.in_bits[IN_WIDTH-1:LO_BITS];
  assign lo_field = bus.in_bits[LO_BITS-1:0];

  always_comb begin
    pre      = '0;
    pre.mode = mode_e'(bus.in_mode);
    pre.err  = {1'b0, bus.in_bits} >= OUT_LIMIT;
    for (int j = 0; j < HI_N; j++) begin
      pre.hi_oh[j] = (hi_field == HI_BITS'(j));
      pre.hi_gt[j] = (HI_BITS'(j) < hi_field);
    end
    for (int k = 0; k < LO_N; k++) begin
      pre.lo_oh[k] = (lo_field == LO_BITS'(k));
      pre.lo_th[k] = (LO_BITS'(k) <= lo_field);
    end
  end

  decoder_pipe_slice #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pre),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1)
  );

  // Output bit i lives in high group i>>LO_BITS at low position i&mask.
  // Thermometer: every lower group is full, the index's own group fills up
  // to the low field.
  always_comb begin
    comb     = '0;
    comb.err = s1.err;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (s1.mode == MODE_THERM) begin
        comb.bits[i] = s1.hi_gt[i >> LO_BITS] |
                       (s1.hi_oh[i >> LO_BITS] & s1.lo_th[i & LO_MASK]);
      end else begin
        comb.bits[i] = s1.hi_oh[i >> LO_BITS] & s1.lo_oh[i & LO_MASK];
      end
    end
    if (s1.err) comb.bits = '0;
  end

  decoder_pipe_slice #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (comb),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2)
  );

  assign bus.out_bits = s2.bits;
  assign bus.out_err  = s2.err;

`ifdef DECODER_PIPE_COUNT_EN
  logic               out_fire;
  logic [COUNT_W-1:0] xfer_count_q, xfer_count_d;
  logic [COUNT_W-1:0] err_count_q, err_count_d;

  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    xfer_count_d = xfer_count_q;
    err_count_d  = err_count_q;
    if (out_fire) begin
      xfer_count_d = xfer_count_q + COUNT_W'(1);
      if (bus.out_err) err_count_d = err_count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
  assign err_count  = err_count_q;
`endif
endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: a full-width instance (OUT_WIDTH=256) and a
// truncated one (OUT_WIDTH=200) driven with identical stimulus.
module tb_decoder_pipe;
  import decoder_pkg::*;

  localparam int IW   = 8;
  localparam int OW_A = 256;
  localparam int OW_B = 200;
  localparam int EW   = OW_A + 1;   // {err, bits} with bits padded to OW_A
  localparam int TO   = 40;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decoder_pipe_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW_A)) bus_a ();
  decoder_pipe_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW_B)) bus_b ();

`ifdef DECODER_PIPE_COUNT_EN
  logic [COUNT_W-1:0] xfer_count_a, err_count_a, xfer_count_b, err_count_b;
`endif

  decoder_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW_A), .LO_BITS(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
`ifdef DECODER_PIPE_COUNT_EN
    ,
    .xfer_count (xfer_count_a),
    .err_count  (err_count_a)
`endif
  );

  decoder_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW_B), .LO_BITS(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
`ifdef DECODER_PIPE_COUNT_EN
    ,
    .xfer_count (xfer_count_b),
    .err_count  (err_count_b)
`endif
  );

  logic [EW-1:0] act_a, act_b;
  assign act_a = {bus_a.out_err, bus_a.out_bits};
  assign act_b = {bus_b.out_err, {(OW_A-OW_B){1'b0}}, bus_b.out_bits};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];
  int xfer_cyc_q[$];

  // Decoded vector straight from the definition: one-hot sets bit idx,
  // thermometer sets bits 0..idx, out-of-range gives err with no bits.
  function automatic logic [EW-1:0] model(input int idx, input logic mode, input int ow);
    logic [EW-1:0] r;
    r = '0;
    if (idx >= ow) r[EW-1] = 1'b1;
    else for (int i = 0; i < ow; i++) r[i] = mode ? (i <= idx) : (i == idx);
    return r;
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got err=%0b bits=%h, want err=%0b bits=%h",
               name, act[EW-1], act[EW-2:0], exp[EW-1], exp[EW-2:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Compare process: every cycle with a valid output, check it against the
  // head of the expected queue; pop on an output transfer.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst_n) begin
      if (bus_a.out_valid) begin
        if (exp_a_q.size() == 0) begin
          total++; bad++;
          $display("FAIL a_extra: got output bits=%h, want no output", bus_a.out_bits);
        end else begin
          check("a_stream", act_a, exp_a_q[0]);
          if (bus_a.out_ready) begin
            void'(exp_a_q.pop_front());
            xfer_cyc_q.push_back(cyc);
          end
        end
      end
      if (bus_b.out_valid) begin
        if (exp_b_q.size() == 0) begin
          total++; bad++;
          $display("FAIL b_extra: got output bits=%h, want no output", bus_b.out_bits);
        end else begin
          check("b_stream", act_b, exp_b_q[0]);
          if (bus_b.out_ready) void'(exp_b_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input int idx, input logic mode);
    bus_a.in_valid = v;
    bus_b.in_valid = v;
    bus_a.in_bits  = idx[IW-1:0];
    bus_b.in_bits  = idx[IW-1:0];
    bus_a.in_mode  = mode;
    bus_b.in_mode  = mode;
  endtask

  task automatic set_ready(input logic r);
    bus_a.out_ready = r;
    bus_b.out_ready = r;
  endtask

  task automatic push_model(input int idx, input logic mode);
    exp_a_q.push_back(model(idx, mode, OW_A));
    exp_b_q.push_back(model(idx, mode, OW_B));
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int idx, input logic mode);
    int waits;
    waits = 0;
    set_in(1'b1, idx, mode);
    #1;
    while (!(bus_a.in_ready && bus_b.in_ready) && waits < TO) begin
      @(negedge clk);
      #1;
      waits++;
    end
    total++;
    if (!(bus_a.in_ready && bus_b.in_ready)) begin
      bad++;
      $display("FAIL send_timeout: index %0d not accepted after %0d cycles, want accepted", idx, waits);
    end else begin
      push_model(idx, mode);
    end
    @(negedge clk);
    set_in(1'b0, 0, 1'b0);
  endtask

  // Single transfer into an empty pipeline with out_ready=1: pins latency and
  // the decoded value against hand-computed literals.
  task automatic send_expect(input string name, input int idx, input logic mode,
                             input logic [EW-1:0] ea, input logic [EW-1:0] eb);
    send(idx, mode);
    #3;
    check_int({name, "_early"}, int'(bus_a.out_valid), 0);
    @(negedge clk);
    #3;
    check_int({name, "_valid"}, int'(bus_a.out_valid), 1);
    check({name, "_a"}, act_a, ea);
    check({name, "_b"}, act_b, eb);
    @(negedge clk);
  endtask

  // ---------------- directed test ----------------
  initial begin
    logic [EW-1:0] la, lb;
    int acc;
    int span;

    set_in(1'b0, 0, 1'b0);
    set_ready(1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("rst_out_a", act_a, '0);
    check("rst_out_b", act_b, '0);
    check_int("rst_out_valid", int'(bus_a.out_valid), 0);
    check_int("rst_in_ready", int'(bus_a.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    la = '0; la[0] = 1'b1;
    send_expect("onehot_0", 0, MODE_ONEHOT, la, la);
    la = '0; la[5:0] = '1;
    send_expect("therm_5", 5, MODE_THERM, la, la);
    la = '0; la[15:0] = '1;
    send_expect("therm_15", 15, MODE_THERM, la, la);
    la = '0; la[16] = 1'b1;
    send_expect("onehot_16", 16, MODE_ONEHOT, la, la);
    la = '0; la[255:0] = '1; lb = '0; lb[EW-1] = 1'b1;
    send_expect("therm_255", 255, MODE_THERM, la, lb);
    la = '0; la[201] = 1'b1;
    send_expect("onehot_201", 201, MODE_ONEHOT, la, lb);
    la = '0; la[200:0] = '1;
    send_expect("therm_200", 200, MODE_THERM, la, lb);
    la = '0; la[199] = 1'b1;
    send_expect("onehot_199", 199, MODE_ONEHOT, la, la);

    // Back-to-back stream at full throughput.
    xfer_cyc_q.delete();
    for (int i = 0; i < 10; i++) send(i, i[0]);
    repeat (4) @(negedge clk);
    span = (xfer_cyc_q.size() > 0) ? xfer_cyc_q[xfer_cyc_q.size()-1] - xfer_cyc_q[0] : -1;
    check_int("stream_count", xfer_cyc_q.size(), 10);
    check_int("stream_span", span, 9);

    // Backpressure: two entries fill the pipe, then in_ready drops.
    set_ready(1'b0);
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      set_in(1'b1, 20 + acc, MODE_ONEHOT);
      #1;
      if (bus_a.in_ready && bus_b.in_ready) begin
        push_model(20 + acc, MODE_ONEHOT);
        acc++;
      end
      @(negedge clk);
    end
    #3;
    check_int("stall_accepts", acc, 2);
    check_int("stall_in_ready", int'(bus_a.in_ready), 0);
    la = '0; la[20] = 1'b1;
    check("stall_hold_a", act_a, la);
    check("stall_hold_b", act_b, la);
    @(negedge clk);
    set_in(1'b0, 0, 1'b0);
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check_int("drain_a", exp_a_q.size(), 0);
    check_int("drain_b", exp_b_q.size(), 0);

    // Asynchronous reset with two entries in flight.
    set_ready(1'b0);
    send(30, MODE_ONEHOT);
    send(31, MODE_ONEHOT);
    #3;
    check_int("pre_rst_valid", int'(bus_a.out_valid), 1);
    rst_n = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    #1;
    check_int("rst_async_valid", int'(bus_a.out_valid), 0);
    check_int("rst_async_in_ready", int'(bus_a.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    la = '0; la[7:0] = '1;
    send_expect("post_rst_therm_7", 7, MODE_THERM, la, la);

`ifdef DECODER_PIPE_COUNT_EN
    rst_n = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    // Indices 213, 216, 219 are out of range for the 200-wide instance only.
    for (int i = 0; i < 10; i++) send((i > 0 && i % 3 == 0) ? 210 + i : i, MODE_ONEHOT);
    repeat (4) @(negedge clk);
    check_int("xfer_count_a", int'(xfer_count_a), 10);
    check_int("err_count_a", int'(err_count_a), 0);
    check_int("xfer_count_b", int'(xfer_count_b), 10);
    check_int("err_count_b", int'(err_count_b), 3);
`endif

    check_int("end_queue_a", exp_a_q.size(), 0);
    check_int("end_queue_b", exp_b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
